// File: rtl/grid_cursor_param.sv
// grid_cursor_param: COLS x ROWS keypad cursor with edge-triggered moves, hold-to-repeat,
// optional wrap-around and a per-cell disable mask with automatic relocation.
module grid_cursor_param #(
   parameter int COLS          = 6,
   parameter int ROWS          = 4,
   parameter int WRAP          = 0,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            dir_up,
   input  logic                            dir_down,
   input  logic                            dir_left,
   input  logic                            dir_right,
   input  logic                            mask_en,
   input  logic [COLS*ROWS-1:0]            cell_mask,
   output logic [$clog2(COLS)-1:0]         pos_x,
   output logic [$clog2(ROWS)-1:0]         pos_y,
   output logic [$clog2(COLS*ROWS)-1:0]    val,
   output logic                            moved
);
   localparam int CELLS = COLS * ROWS;
   localparam int XW    = $clog2(COLS);
   localparam int YW    = $clog2(ROWS);
   localparam int VW    = $clog2(CELLS);
   localparam int CW    = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
   localparam int SPAN  = COLS > ROWS ? COLS : ROWS;

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [1:0]      last_dir;
   logic            act, fresh, step, hit, r_ok, cur_off, go, stop, at_end;
   logic [1:0]      dir;
   logic [XW-1:0]   tx, rx, nx;
   logic [YW-1:0]   ty, ry, ny;
   int              cx, cy;

   // dir encoding: bit1 selects the x axis, bit0 selects the increasing direction
   assign act   = dir_up | dir_down | dir_left | dir_right;
   assign dir   = dir_up ? 2'd0 : dir_down ? 2'd1 : dir_left ? 2'd2 : 2'd3;
   assign fresh = state == IDLE || dir != last_dir;
   assign step  = act && (fresh || cnt == (state == DELAY ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_PERIOD - 1)));

   // Walk along the row/column until an enabled cell, the edge (clamp) or the start (wrap)
   always_comb begin
      cx = int'(pos_x);
      cy = int'(pos_y);
      stop = 1'b0;
      at_end = 1'b0;
      hit = 1'b0;
      tx = pos_x;
      ty = pos_y;
      for (int i = 0; i < SPAN; i++) begin
         if (!stop && !hit) begin
            if (dir[1]) begin
               at_end = dir[0] ? cx == COLS - 1 : cx == 0;
               cx = at_end ? (dir[0] ? 0 : COLS - 1) : (dir[0] ? cx + 1 : cx - 1);
            end else begin
               at_end = dir[0] ? cy == ROWS - 1 : cy == 0;
               cy = at_end ? (dir[0] ? 0 : ROWS - 1) : (dir[0] ? cy + 1 : cy - 1);
            end
            if ((at_end && WRAP == 0) || (cx == int'(pos_x) && cy == int'(pos_y)))
               stop = 1'b1;
            else if (!mask_en || !cell_mask[VW'(cy * COLS + cx)]) begin
               hit = 1'b1;
               tx = XW'(cx);
               ty = YW'(cy);
            end
         end
      end
   end

   always_comb begin
      r_ok = 1'b0;
      rx = '0;
      ry = '0;
      for (int i = CELLS - 1; i >= 0; i--)
         if (!cell_mask[i]) begin
            r_ok = 1'b1;
            rx = XW'(i % COLS);
            ry = YW'(i / COLS);
         end
   end

   assign cur_off = mask_en && cell_mask[val];
   assign go      = cur_off ? r_ok : step && hit;
   assign nx      = cur_off ? rx : tx;
   assign ny      = cur_off ? ry : ty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         last_dir <= '0;
         pos_x    <= '0;
         pos_y    <= '0;
         val      <= '0;
         moved    <= 1'b0;
      end else begin
         state    <= !act ? IDLE : fresh ? DELAY : step ? REPEAT : state;
         cnt      <= (!act || step) ? '0 : (&cnt ? cnt : cnt + 1'b1);
         last_dir <= dir;
         moved    <= go;
         if (go) begin
            pos_x <= nx;
            pos_y <= ny;
            val   <= VW'(int'(ny) * COLS + int'(nx));
         end
      end
   end
endmodule

// File: tb/tb_grid_cursor_param.sv
// tb_grid_cursor_param: directed checks of a clamping and a wrapping 6x4 cursor sharing stimulus.
module tb_grid_cursor_param;
   logic        clk = 1'b0, rst = 1'b0;
   logic        up = 1'b0, dn = 1'b0, lf = 1'b0, rt = 1'b0, mask_en = 1'b0;
   logic [23:0] cell_mask = '0;
   logic [2:0]  x0, x1;
   logic [1:0]  y0, y1;
   logic [4:0]  v0, v1;
   logic        m0, m1;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   grid_cursor_param #(.COLS(6), .ROWS(4), .WRAP(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) u0 (
      .clk(clk), .rst(rst), .dir_up(up), .dir_down(dn), .dir_left(lf), .dir_right(rt),
      .mask_en(mask_en), .cell_mask(cell_mask), .pos_x(x0), .pos_y(y0), .val(v0), .moved(m0));

   grid_cursor_param #(.COLS(6), .ROWS(4), .WRAP(1), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) u1 (
      .clk(clk), .rst(rst), .dir_up(up), .dir_down(dn), .dir_left(lf), .dir_right(rt),
      .mask_en(mask_en), .cell_mask(cell_mask), .pos_x(x1), .pos_y(y1), .val(v1), .moved(m1));

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      {up, dn, lf, rt} = 4'b0;
      mask_en = 1'b0;
      cell_mask = '0;
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
   endtask

   // d: 0 up, 1 down, 2 left, 3 right
   task automatic pulse(input int d);
      {up, dn, lf, rt} = 4'b1000 >> d;
      tick();
      {up, dn, lf, rt} = 4'b0;
      tick();
   endtask

   initial begin
      // 1: reset values and a single right press
      do_reset();
      chk("rst x", x0, 0); chk("rst y", y0, 0); chk("rst val", v0, 0); chk("rst moved", m0, 0);
      rt = 1'b1; tick();
      chk("t1 x", x0, 1); chk("t1 y", y0, 0); chk("t1 val", v0, 1); chk("t1 moved", m0, 1);
      rt = 1'b0; tick();
      chk("t1 moved drop", m0, 0);
      repeat (5) tick();
      chk("t1 idle x", x0, 1); chk("t1 idle val", v0, 1); chk("t1 idle moved", m0, 0);

      // 2: hold right, repeat timing and clamp at the right edge
      do_reset();
      rt = 1'b1;
      for (int e = 0; e < 14; e++) begin
         tick();
         chk($sformatf("t2 x e%0d", e), x0, e < 4 ? 1 : e < 6 ? 2 : e < 8 ? 3 : e < 10 ? 4 : 5);
         chk($sformatf("t2 moved e%0d", e), m0, (e == 0 || e == 4 || e == 6 || e == 8 || e == 10) ? 1 : 0);
      end
      rt = 1'b0; tick();

      // 3: wrap-around (u1) versus clamp (u0)
      do_reset();
      pulse(1); pulse(1);
      lf = 1'b1; tick();
      chk("t3 wrap x", x1, 5); chk("t3 wrap val", v1, 17); chk("t3 wrap moved", m1, 1);
      chk("t3 clamp val", v0, 12); chk("t3 clamp moved", m0, 0);
      lf = 1'b0; tick();
      pulse(1); pulse(2); pulse(2);
      chk("t3 pre val", v1, 21);
      dn = 1'b1; tick();
      chk("t3 wrapdn y", y1, 0); chk("t3 wrapdn val", v1, 3); chk("t3 wrapdn moved", m1, 1);
      chk("t3 clampdn val", v0, 18); chk("t3 clampdn moved", m0, 0);
      dn = 1'b0; tick();

      // 4: masked skipping, relocation, all-disabled hold
      do_reset();
      pulse(3);
      mask_en = 1'b1;
      cell_mask = 24'h00003C;
      pulse(3);
      chk("t4 skip clamp val", v0, 1); chk("t4 skip wrap val", v1, 0);
      do_reset();
      pulse(3);
      mask_en = 1'b1;
      cell_mask = 24'h00000C;
      rt = 1'b1; tick();
      chk("t4 skip x", x0, 4); chk("t4 skip val", v0, 4); chk("t4 skip moved", m0, 1);
      rt = 1'b0; tick();
      cell_mask = 24'h00001C; tick();
      chk("t4 reloc val", v0, 0); chk("t4 reloc moved", m0, 1);
      cell_mask = 24'hFFFFFF; tick();
      chk("t4 all off val", v0, 0); chk("t4 all off moved", m0, 0);
      mask_en = 1'b0; cell_mask = '0; tick();

      // 5: priority and direction change as a new press
      do_reset();
      pulse(3); pulse(3); pulse(1); pulse(1);
      chk("t5 start val", v0, 14);
      up = 1'b1; rt = 1'b1; tick();
      chk("t5 prio x", x0, 2); chk("t5 prio y", y0, 1); chk("t5 prio val", v0, 8);
      up = 1'b0; tick();
      chk("t5 change val", v0, 9); chk("t5 change moved", m0, 1);
      repeat (3) tick();
      chk("t5 delay val", v0, 9);
      tick();
      chk("t5 repeat val", v0, 10); chk("t5 repeat moved", m0, 1);
      rt = 1'b0; tick();

      // 6: asynchronous reset mid-repeat with direction still held
      do_reset();
      dn = 1'b1;
      repeat (8) tick();
      chk("t6 held y", y0, 3);
      #2 rst = 1'b0;
      #1 chk("t6 async y", y0, 0); chk("t6 async val", v0, 0);
      tick();
      chk("t6 in rst y", y0, 0);
      rst = 1'b1; tick();
      chk("t6 first y", y0, 1); chk("t6 first moved", m0, 1);
      repeat (3) tick();
      chk("t6 wait y", y0, 1);
      tick();
      chk("t6 second y", y0, 2); chk("t6 second val", v0, 12);
      dn = 1'b0; tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/grid_cursor_param.md
# grid_cursor_param

Parametrised keypad-grid cursor for the calculator front end. It tracks a cursor on a COLS x ROWS grid from four direction inputs and outputs the position and the linear cell code. The display renderer and the key decoder consume these outputs. Over the fixed 6x4 generation it adds edge-triggered moves with hold-to-repeat, optional wrap-around, and a per-cell disable mask that replaces the hard-coded restriction mode.

## Interface
- COLS, 6: grid columns (>=2).
- ROWS, 4: grid rows (>=2).
- WRAP, 0: 1 = moving off an edge wraps to the opposite edge; 0 = clamp.
- REPEAT_DELAY, 25_000_000: cycles a direction must be held before the first auto-repeat (>=2).
- REPEAT_PERIOD, 5_000_000: cycles between auto-repeats (>=1).
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- dir_up, dir_down, dir_left, dir_right  in  1 each  direction requests, already synchronised and debounced upstream.
- mask_en  in  1  enables cell_mask.
- cell_mask  in  COLS*ROWS  bit i = 1 disables cell i (i = y*COLS + x).
- pos_x  out  $clog2(COLS)  cursor column.
- pos_y  out  $clog2(ROWS)  cursor row.
- val  out  $clog2(COLS*ROWS)  pos_y*COLS + pos_x, registered.
- moved  out  1  one-cycle pulse when the position changed on the previous edge.

## Operation
- Active direction is chosen by priority: up > down > left > right. At most one move per cycle.
- FSM states:
  - IDLE: no direction active.
  - DELAY: direction held; counting toward REPEAT_DELAY.
  - REPEAT: counting toward REPEAT_PERIOD.
- Transitions:
  - IDLE -> DELAY when a direction becomes active. Issue one move; clear the counter.
  - DELAY -> REPEAT when the counter reaches REPEAT_DELAY-1. Issue a move; clear the counter.
  - REPEAT: when the counter reaches REPEAT_PERIOD-1, issue a move and clear the counter.
  - Any state -> IDLE when no direction is active.
  - In DELAY or REPEAT, a change of active direction counts as a new press: move immediately, enter DELAY, clear the counter.
- Step target: one cell in the active direction.
  - Target off-grid with WRAP=0: position unchanged, moved stays 0.
  - Target off-grid with WRAP=1: target is the opposite edge of the same row or column.
- Mask (mask_en=1):
  - A disabled target is skipped. The search continues in the same direction along the same row or column; wrapping applies if WRAP=1.
  - The first enabled cell wins.
  - If no enabled cell is found before the search returns to the start (WRAP=1) or reaches the edge (WRAP=0), the position is unchanged.
- Relocation: if mask_en=1 and the current cell is disabled, the next edge moves the cursor to the lowest-index enabled cell and pulses moved. If every cell is disabled, the cursor holds. Relocation takes precedence over a direction move in the same cycle; the FSM still advances.
- mask_en=0 ignores cell_mask entirely.
- Non-power-of-two COLS or ROWS: pos values >= COLS or ROWS are never produced.

## Timing
- Reset values: pos_x=0, pos_y=0, val=0, moved=0, FSM=IDLE, counter=0. Reset mid-hold aborts the repeat.
- After reset release, a direction still held counts as a new press on the first active edge.
- A move issued at edge k updates pos_x, pos_y and val at edge k. moved is high for the cycle following edge k.
- A direction first seen high before edge k gives moves at edges k, k+REPEAT_DELAY, k+REPEAT_DELAY+REPEAT_PERIOD, and so on.
- Counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)). The counter saturates and never wraps.
- Mask changes take effect on the next edge. No combinational path from inputs to outputs.

## Test plan
All scenarios use COLS=6, ROWS=4, REPEAT_DELAY=4, REPEAT_PERIOD=2 unless noted.
1. Reset, then dir_right high for 1 cycle -> pos=(1,0), val=1, moved high for exactly 1 cycle. Then 5 idle cycles -> no further change.
2. From (0,0), hold dir_right for 12 cycles -> moves at edges 0, 4, 6, 8, 10 -> pos_x 1, 2, 3, 4, 5. Further hold keeps pos_x=5 with moved=0 (WRAP=0).
3. WRAP=1, cursor at (0,2), dir_left pulse -> pos=(5,2), val=17. From (3,3), dir_down pulse -> (3,0), val=3.
4. mask_en=1, cell_mask bits 2 and 3 set, cursor at (1,0), dir_right pulse -> pos=(4,0), val=4. Then set bit 4 -> next edge relocates to (0,0) and moved pulses.
5. dir_up and dir_right asserted together at (2,2) -> only up -> (2,1). Release up while keeping right -> immediate move to (3,1) and a new REPEAT_DELAY begins.
6. Hold dir_down into REPEAT, assert rst low mid-period -> outputs go to 0 asynchronously. After release with dir_down still high -> one move at the first edge to (0,1), then the next at +4 cycles.
